// File: rtl/test_runner_pkg.sv
// test_runner_pkg: sequencer state encoding and timing constants
// shared by the fixture test runner files.
package test_runner_pkg;

   typedef enum logic [2:0] {
      ST_STARTUP,
      ST_LAUNCH,
      ST_SETTLE,
      ST_WAIT,
      ST_DONE
   } state_e;

   localparam int SETTLE_CYCLES = 2;
   localparam int GAP_MULT      = 4;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/test_runner_if.sv
// test_runner_if: start strobe / busy / verdict bundle between the
// runner (master) and its N fixtures (slave).
interface test_runner_if #(
   parameter int N_TESTS = 4
) ();

   logic [N_TESTS-1:0] o_run;
   logic [N_TESTS-1:0] i_running;
   logic [N_TESTS-1:0] i_passed;

   modport master (
      output o_run,
      input  i_running,
      input  i_passed
   );

   modport slave (
      input  o_run,
      output i_running,
      output i_passed
   );

endinterface

// File: rtl/test_runner_blink_coder.sv
// blink_coder: red blink code, (count+1) pulses then a dark gap.
// Only built when TEST_RUNNER_BLINK_CODE_EN is defined.
`ifdef TEST_RUNNER_BLINK_CODE_EN
module blink_coder
   import test_runner_pkg::*;
#(
   parameter int IW           = 2,
   parameter int BLINK_CYCLES = 6000000
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   input  logic [IW-1:0] i_count,
   output logic          o_pulse
);

   localparam int TW = $clog2(BLINK_CYCLES + 1);
   localparam int PW = IW + 3;
   localparam logic [TW-1:0] T_LAST = TW'(BLINK_CYCLES - 1);

   logic [TW-1:0] tick_q;
   logic [PW-1:0] ph_q;
   logic [PW-1:0] n_on;
   logic [PW-1:0] ph_last;

   // ph_q counts half-periods: even ones below n_on are lit
   assign n_on    = PW'({i_count, 1'b0}) + PW'(2);
   assign ph_last = n_on + PW'(GAP_MULT - 1);
   assign o_pulse = i_en & (ph_q < n_on) & ~ph_q[0];

   always_ff @(posedge i_clk) begin
      if (i_rst || !i_en) begin
         tick_q <= '0;
         ph_q   <= '0;
      end else if (tick_q == T_LAST) begin
         tick_q <= '0;
         ph_q   <= (ph_q == ph_last) ? '0 : ph_q + 1'b1;
      end else begin
         tick_q <= tick_q + 1'b1;
      end
   end

endmodule
`endif

// File: rtl/test_runner.sv
// test_runner: runs N fixtures in turn after start-up, with a per-test
// watchdog. Red blink code when TEST_RUNNER_BLINK_CODE_EN is defined.
module test_runner
   import test_runner_pkg::*;
#(
   parameter int N_TESTS        = 4,
   parameter int STARTUP_CYCLES = 64,
   parameter int TIMEOUT_CYCLES = 2**20,
   parameter int STOP_ON_FAIL   = 1
`ifdef TEST_RUNNER_BLINK_CODE_EN
   ,
   parameter int BLINK_CYCLES   = 6000000
`endif
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   test_runner_if.master               fx,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_pass,
   output logic [N_TESTS-1:0]          o_fail_mask,
   output logic [idx_w(N_TESTS)-1:0]   o_fail_idx,
   output logic                        o_timeout,
   output logic                        o_led_r,
   output logic                        o_led_g,
   output logic                        o_led_b
);

   localparam int IW = idx_w(N_TESTS);
   localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int CW = $clog2(STARTUP_CYCLES + 1) + 1;
   localparam logic [CW-1:0] SU_LAST = CW'(STARTUP_CYCLES - 1);
   localparam logic [CW-1:0] SE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] K_LAST  = IW'(N_TESTS - 1);
   localparam bit            STOP    = (STOP_ON_FAIL != 0);

   state_e             state_q;
   logic [CW-1:0]      cnt_q;
   logic [WW-1:0]      wd_q;
   logic [IW-1:0]      k_q;
   logic [IW-1:0]      k_nx;
   logic [IW-1:0]      idx_q;
   logic [N_TESTS-1:0] run_q;
   logic [N_TESTS-1:0] mask_q;
   logic [N_TESTS-1:0] mask_d;
   logic               busy_q, done_q, pass_q, tmo_q;
   logic               cmp, tmo_hit, fin, fail, last;

   // completion has priority: a timeout needs the fixture still running
   always_comb begin
      cmp     = ~fx.i_running[k_q];
      tmo_hit = fx.i_running[k_q] & (wd_q == WD_LAST);
      fin     = cmp | tmo_hit;
      fail    = tmo_hit | (cmp & ~fx.i_passed[k_q]);
      last    = (k_q == K_LAST);
      k_nx    = k_q + 1'b1;
      mask_d  = mask_q;
      if (fail) mask_d[k_q] = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_STARTUP;
         cnt_q   <= '0;
         wd_q    <= '0;
         k_q     <= '0;
         run_q   <= '0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mask_q  <= '0;
         idx_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         run_q <= '0;
         unique case (state_q)
            ST_STARTUP: begin
               if (cnt_q == SU_LAST) begin
                  cnt_q    <= '0;
                  k_q      <= '0;
                  run_q[0] <= 1'b1;
                  state_q  <= ST_LAUNCH;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_LAUNCH: begin
               wd_q    <= '0;
               cnt_q   <= '0;
               state_q <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (cnt_q == SE_LAST) state_q <= ST_WAIT;
               else cnt_q <= cnt_q + 1'b1;
            end
            ST_WAIT: begin
               if (fin) begin
                  mask_q <= mask_d;
                  if (fail && mask_q == '0) begin
                     idx_q <= k_q;
                     tmo_q <= tmo_hit;
                  end
                  if ((fail && STOP) || last) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (mask_d == '0);
                  end else begin
                     k_q         <= k_nx;
                     run_q[k_nx] <= 1'b1;
                     state_q     <= ST_LAUNCH;
                  end
               end else if (wd_q != '1) begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            ST_DONE: state_q <= ST_DONE;
            default: state_q <= ST_STARTUP;
         endcase
      end
   end

   assign fx.o_run    = run_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_pass      = pass_q;
   assign o_fail_mask = mask_q;
   assign o_fail_idx  = idx_q;
   assign o_timeout   = tmo_q;
   assign o_led_b     = busy_q;
   assign o_led_g     = done_q & pass_q;

`ifdef TEST_RUNNER_BLINK_CODE_EN
   logic blink;

   blink_coder #(
      .IW           (IW),
      .BLINK_CYCLES (BLINK_CYCLES)
   ) u_blink (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (done_q & ~pass_q),
      .i_count (idx_q),
      .o_pulse (blink)
   );

   assign o_led_r = blink;
`else
   assign o_led_r = done_q & ~pass_q;
`endif

endmodule

// File: tb/tb_test_runner.sv
// tb_test_runner: two runners (stop-on-fail and continue) driven by
// modelled fixtures; launch times and verdicts from a schedule model.
module tb_test_runner;

   localparam int N  = 4;
   localparam int SU = 8;
   localparam int TO = 16;
   localparam int WL = TO + 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   test_runner_if #(.N_TESTS(N)) fx0 ();
   test_runner_if #(.N_TESTS(N)) fx1 ();

   wire [1:0]   busy_v, done_v, pass_v, tmo_v, lr_v, lg_v, lb_v;
   wire [N-1:0] mask_v [2];
   wire [1:0]   idx_v  [2];

   test_runner #(
      .N_TESTS(N), .STARTUP_CYCLES(SU),
      .TIMEOUT_CYCLES(TO), .STOP_ON_FAIL(1)
   ) u_stop (
      .i_clk(clk), .i_rst(rst), .fx(fx0),
      .o_busy(busy_v[0]), .o_done(done_v[0]), .o_pass(pass_v[0]),
      .o_fail_mask(mask_v[0]), .o_fail_idx(idx_v[0]),
      .o_timeout(tmo_v[0]),
      .o_led_r(lr_v[0]), .o_led_g(lg_v[0]), .o_led_b(lb_v[0])
   );

   test_runner #(
      .N_TESTS(N), .STARTUP_CYCLES(SU),
      .TIMEOUT_CYCLES(TO), .STOP_ON_FAIL(0)
   ) u_cont (
      .i_clk(clk), .i_rst(rst), .fx(fx1),
      .o_busy(busy_v[1]), .o_done(done_v[1]), .o_pass(pass_v[1]),
      .o_fail_mask(mask_v[1]), .o_fail_idx(idx_v[1]),
      .o_timeout(tmo_v[1]),
      .o_led_r(lr_v[1]), .o_led_g(lg_v[1]), .o_led_b(lb_v[1])
   );

   int nchk = 0;
   int nbad = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // fixture behaviour: busy for dur[k] cycles from its strobe, then verdict
   int dur [N];
   bit verd [N];

   int         exp_launch [2][N];
   int         exp_nl   [2];
   int         exp_done [2];
   logic [N-1:0] exp_mask [2];
   int         exp_idx  [2];
   bit         exp_tmo  [2];

   int act [2];
   int start [2];
   int nl [2];
   int done_at [2];
   int base = 0;

   // schedule: LAUNCH + 2 settle, then verdict at max(3,dur) or timeout at WL
   task automatic build_model();
      int t, jend;
      bit hang, f;
      for (int d = 0; d < 2; d++) begin
         t = SU;
         exp_mask[d] = '0;
         exp_idx[d] = 0;
         exp_tmo[d] = 1'b0;
         exp_nl[d] = 0;
         for (int k = 0; k < N; k++) begin
            hang = dur[k] > WL;
            f = hang || !verd[k];
            jend = hang ? WL : (dur[k] < 3 ? 3 : dur[k]);
            exp_launch[d][k] = t;
            exp_nl[d]++;
            t = t + jend + 1;
            if (f) begin
               if (exp_mask[d] == '0) begin
                  exp_idx[d] = k;
                  exp_tmo[d] = hang;
               end
               exp_mask[d][k] = 1'b1;
            end
            if (f && d == 0) break;
         end
         exp_done[d] = t;
      end
   endtask

   task automatic drive_random(input int d);
      logic [N-1:0] r, p;
      r = N'($urandom);
      p = N'($urandom);
      if (d == 0) begin
         fx0.i_running = r;
         fx0.i_passed  = p;
      end else begin
         fx1.i_running = r;
         fx1.i_passed  = p;
      end
   endtask

   task automatic step();
      int rel, j;
      logic [N-1:0] run, r, p;
      @(negedge clk);
      rel = cyc - base;
      for (int d = 0; d < 2; d++) begin
         run = (d == 0) ? fx0.o_run : fx1.o_run;
         if (run != '0) begin
            if (nl[d] < exp_nl[d]) begin
               check($sformatf("run_bits d%0d k%0d", d, nl[d]),
                     32'(run), 32'(1) << nl[d]);
               check($sformatf("run_time d%0d k%0d", d, nl[d]),
                     rel, exp_launch[d][nl[d]]);
               act[d] = nl[d];
               start[d] = rel;
            end else begin
               check($sformatf("extra_run d%0d", d), nl[d] + 1, exp_nl[d]);
            end
            nl[d]++;
         end
         if (done_v[d] && done_at[d] < 0) done_at[d] = rel;
         r = N'($urandom);
         p = N'($urandom);
         if (act[d] >= 0) begin
            j = rel - start[d];
            r[act[d]] = (j < dur[act[d]]);
            if (j >= dur[act[d]]) p[act[d]] = verd[act[d]];
         end
         if (d == 0) begin
            fx0.i_running = r;
            fx0.i_passed  = p;
         end else begin
            fx1.i_running = r;
            fx1.i_passed  = p;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_random(0);
      drive_random(1);
      @(negedge clk);
      rst = 1'b0;
      base = cyc;
      for (int d = 0; d < 2; d++) begin
         act[d] = -1;
         nl[d] = 0;
         done_at[d] = -1;
         check($sformatf("rst_busy d%0d", d), busy_v[d], 1);
         check($sformatf("rst_done d%0d", d), done_v[d], 0);
         check($sformatf("rst_pass d%0d", d), pass_v[d], 0);
         check($sformatf("rst_mask d%0d", d), mask_v[d], 0);
         check($sformatf("rst_idx d%0d", d), idx_v[d], 0);
         check($sformatf("rst_tmo d%0d", d), tmo_v[d], 0);
         check($sformatf("rst_leds d%0d", d), {lr_v[d], lg_v[d], lb_v[d]}, 3'b001);
      end
      check("rst_run0", fx0.o_run, 0);
      check("rst_run1", fx1.o_run, 0);
   endtask

   task automatic run_scn(input bit abort);
      int lim;
      build_model();
      do_reset();
      if (abort) begin
         while (cyc - base < exp_launch[1][1] + 5) step();
         do_reset();
      end
      lim = (exp_done[0] > exp_done[1] ? exp_done[0] : exp_done[1]) + 12;
      while (cyc - base < lim) step();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("done_time d%0d", d), done_at[d], exp_done[d]);
         check($sformatf("launches d%0d", d), nl[d], exp_nl[d]);
         check($sformatf("mask d%0d", d), mask_v[d], exp_mask[d]);
         check($sformatf("pass d%0d", d), pass_v[d], exp_mask[d] == '0);
         check($sformatf("busy d%0d", d), busy_v[d], 0);
         check($sformatf("leds d%0d", d), {lr_v[d], lg_v[d], lb_v[d]},
               (exp_mask[d] == '0) ? 3'b010 : 3'b100);
         if (exp_mask[d] != '0) begin
            check($sformatf("fail_idx d%0d", d), idx_v[d], exp_idx[d]);
            check($sformatf("timeout d%0d", d), tmo_v[d], exp_tmo[d]);
         end
      end
   endtask

   task automatic set_all(input int du, input bit v);
      for (int k = 0; k < N; k++) begin
         dur[k] = du;
         verd[k] = v;
      end
   endtask

   initial begin
      fx0.i_running = '0;
      fx0.i_passed  = '0;
      fx1.i_running = '0;
      fx1.i_passed  = '0;

      set_all(10, 1'b1);
      run_scn(1'b0);

      set_all(10, 1'b1);
      verd[2] = 1'b0;
      run_scn(1'b0);

      set_all(10, 1'b1);
      verd[1] = 1'b0;
      verd[3] = 1'b0;
      run_scn(1'b0);

      set_all(10, 1'b1);
      dur[0] = 1000;
      run_scn(1'b0);

      set_all(WL, 1'b1);
      dur[1] = 0;
      dur[2] = WL + 1;
      dur[3] = 3;
      run_scn(1'b0);

      set_all(10, 1'b1);
      dur[1] = 20;
      run_scn(1'b1);

      for (int s = 0; s < 20; s++) begin
         for (int k = 0; k < N; k++) begin
            dur[k] = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 25);
            verd[k] = ($urandom_range(0, 9) < 7);
         end
         run_scn(1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
      $finish;
   end

endmodule
